imm_extend_stage: RTL



---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_format.sv | 50 +++++
 rtl/imm_extend_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
//   Shared types and constants for the immediate-generation D->E stage.
//   - immsrc_t    : immediate format select as driven by the decode control unit
//   - XLEN_32/64  : the two legal datapath widths
//   - imm_entry_t : one buffered result {imm, err}; imm is sized for the widest
//                   datapath, narrower configurations keep the upper bits at zero
// -----------------------------------------------------------------------------
package imm_pkg;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } immsrc_t;

  typedef struct packed {
    logic [XLEN_64-1:0] imm;
    logic               err;
  } imm_entry_t;

endpackage

// File: rtl/imm_format.sv
// -----------------------------------------------------------------------------
// imm_format
//   Purely combinational immediate decoder. Extracts the immediate selected by
//   immsrc_i from the raw instruction word and sign- or zero-extends it to XLEN.
//   The illegal select code yields zero with err_o set.
//
// Ports
//   instr_i   [31:0]     raw instruction word
//   immsrc_i  [2:0]      immediate format select (immsrc_t encoding)
//   imm_o     [XLEN-1:0] extended immediate
//   err_o                select was the illegal code
// -----------------------------------------------------------------------------
module imm_format
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  logic [5:0] shamt;
  logic       unused_opcode;

  // Bit 5 of the shift amount only exists on a 64-bit datapath.
  assign shamt = {instr_i[25] & (XLEN == XLEN_64), instr_i[24:20]};

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (immsrc_t'(immsrc_i))
      IMM_I:     imm_o = XLEN'($signed(instr_i[31:20]));
      IMM_S:     imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      IMM_B:     imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                         instr_i[11:8], 1'b0}));
      IMM_U:     imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      IMM_J:     imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                         instr_i[30:21], 1'b0}));
      IMM_SHAMT: imm_o = XLEN'(shamt);
      IMM_ZIMM:  imm_o = XLEN'(instr_i[19:15]);
      IMM_ILL:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//   Immediate generator with a registered, back-pressurable D->E boundary.
//   The immediate is formatted combinationally from instrD and captured into a
//   two-entry skid buffer (main + skid). Main drives the outputs; skid absorbs
//   the one extra word accepted while main is stalled, so in_ready depends only
//   on registers.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  decode-side handshake (in_ready = !skid valid)
//   instrD   [31:0]      raw instruction word
//   immsrcD  [2:0]       immediate format select
//   flushE               drop every buffered entry and the current input
//   out_valid/out_ready  execute-side handshake
//   immextE  [XLEN-1:0]  extended immediate (registered)
//   imm_errE             illegal format select (registered)
// -----------------------------------------------------------------------------
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instrD,
  input  logic [2:0]      immsrcD,
  input  logic            flushE,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immextE,
  output logic            imm_errE
);

  logic [XLEN-1:0] fmt_imm;
  logic            fmt_err;
  imm_entry_t      in_entry;

  logic       main_valid_q, main_valid_d;
  imm_entry_t main_q,       main_d;
  logic       skid_valid_q, skid_valid_d;
  imm_entry_t skid_q,       skid_d;

  logic accept;
  logic unused_imm_hi;

  imm_format #(
    .XLEN (XLEN)
  ) u_imm_format (
    .instr_i  (instrD),
    .immsrc_i (immsrcD),
    .imm_o    (fmt_imm),
    .err_o    (fmt_err)
  );

  always_comb begin
    in_entry                = '0;
    in_entry.imm[XLEN-1:0]  = fmt_imm;
    in_entry.err            = fmt_err;
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flushE) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && !out_ready) begin
      // Main stalled: a new word can only land in skid.
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_d       = in_entry;
      end
    end else if (skid_valid_q) begin
      // Main firing with skid occupied (skid implies main valid); in_ready is
      // low this cycle so no new word competes for main.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else begin
      // Main empty or firing, skid empty: straight-through path.
      main_valid_d = accept;
      if (accept) begin
        main_d = in_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign immextE   = main_q.imm[XLEN-1:0];
  assign imm_errE  = main_q.err;

  // Upper entry bits stay zero on a 32-bit datapath.
  assign unused_imm_hi = ^main_q.imm;

endmodule
